conv_sched: RTL and testbench
=============================

CONV_SCHED -- requirements
Module: conv_sched

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; there are no parameters, and all widths are fixed.
REQ-002 i_clk  input  1  single clock; all state updates on the rising edge.
REQ-003 i_rst  input  1  synchronous, active-high reset.
REQ-004 i_start  input  1  request to convolve one 3x3 window; accepted only while o_idle=1.
REQ-005 o_idle  output  1  high in IDLE; i_start is accepted in any cycle where i_start=1 and o_idle=1.
REQ-006 i_win_data  input  72  nine unsigned 8-bit pixels; row r occupies bits [24r+23:24r].
REQ-007 i_win_weight  input  72  nine signed 8-bit weights, with the same packing as i_win_data.
REQ-008 o_pc_data  output  24  row slice driven to the external 3-lane partial-convolution datapath.
REQ-009 o_pc_weight  output  24  row weight slice driven to the same datapath.
REQ-010 i_pconv  input  18  combinational signed partial sum returned by the datapath in the same cycle.
REQ-011 o_valid  output  1  o_result is valid.
REQ-012 i_ready  input  1  consumer accepts o_result when i_ready=1 and o_valid=1.
REQ-013 o_result  output  20  signed accumulated window sum.

Function
REQ-014 On start acceptance, i_win_data and i_win_weight SHALL be latched into internal 72-bit registers; the inputs are don't-care afterwards.
REQ-015 The FSM SHALL have three states:
- IDLE: accepting a start moves to RUN.
- RUN: row counter runs 0,1,2; leaves to DONE after row 2.
- DONE: holds; i_ready=1 moves to IDLE.
REQ-016 In RUN with row=r, o_pc_data and o_pc_weight SHALL carry latched row r; outside RUN, both SHALL be driven to 0.
REQ-017 In RUN, the accumulator SHALL load sext20(i_pconv) at row 0 and add sext20(i_pconv) at rows 1 and 2, using 20-bit two's-complement arithmetic with no overflow possible (3 x 18-bit).
REQ-018 Latency: start accepted at edge T SHALL give RUN for cycles T+1..T+3, with o_valid=1 from cycle T+4.
REQ-019 o_valid SHALL be 1 exactly in DONE; o_result SHALL stay stable while o_valid=1 and i_ready=0.
REQ-020 A handshake in DONE SHALL return the FSM to IDLE; the next start can be accepted one cycle later, giving a minimum period of 5 cycles per window.
REQ-021 i_start asserted outside IDLE SHALL be ignored, with no queuing and no effect on the current window.
REQ-022 i_ready asserted outside DONE SHALL be ignored.
REQ-023 The row counter SHALL reset to 0 on entry to RUN and SHALL never reach 3.

Reset
REQ-024 When i_rst=1 at an edge, the FSM SHALL go to IDLE, with row=0, accumulator=0, and latched window registers=0.
REQ-025 Outputs after reset SHALL be: o_idle=1, o_valid=0, o_result=0, o_pc_data=0, o_pc_weight=0.
REQ-026 Reset SHALL take priority over all other events.
REQ-027 Reset in RUN or DONE SHALL abandon the window with no result produced; a start asserted in the reset cycle SHALL be ignored.

Configuration
REQ-028 Macro CONV_SCHED_RELU_EN SHALL select the output clamp:
- Defined: o_result is 0 whenever the accumulator is negative, otherwise the accumulator.
- Undefined: o_result is the raw signed accumulator.
In both cases the clamp is applied combinationally and does not change latency.

Verification
REQ-029 The bench SHALL model the datapath so that i_pconv returns a scripted value per row, and SHALL cover the following:
- Reset, then idle for 3 cycles -> o_idle=1, o_valid=0, o_result=0, o_pc_*=0.
- Start with rows 0x0A0B0C / weights 0x010203; scripted pconv 100, -50, 7 -> o_pc_data=0x0A0B0C on the first RUN cycle; o_valid at T+4 with o_result=57.
- Scripted pconv -131072, -131072, -131072 -> o_result=-393216 (0xA0000) without CONV_SCHED_RELU_EN; o_result=0 with it.
- i_ready held 0 for 4 cycles after o_valid, with i_start pulsed in DONE -> o_result stable, start ignored, no second window.
- Two back-to-back windows, with i_ready=1 and i_start re-asserted immediately -> results 5 cycles apart, each matching its own pconv script.
- i_rst at the second RUN cycle -> next cycle IDLE, o_valid never asserted; a following start produces a correct fresh result.

Source files
------------

// File: rtl/conv_sched.sv
// 3x3 convolution window scheduler: feeds one row per cycle to an external
// partial-convolution datapath and accumulates its sums. Optional clamp: CONV_SCHED_RELU_EN.
module conv_sched (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  output logic        o_idle,
  input  logic [71:0] i_win_data,
  input  logic [71:0] i_win_weight,
  output logic [23:0] o_pc_data,
  output logic [23:0] o_pc_weight,
  input  logic [17:0] i_pconv,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [19:0] o_result
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q;
  logic [1:0]  row_q;
  logic [19:0] acc_q;
  logic [19:0] acc_d;
  logic [71:0] data_q;
  logic [71:0] weight_q;
  logic        idle_q;
  logic        valid_q;
  logic [19:0] pconv_ext;

  // Row 0 starts a fresh window, so the old accumulator is discarded there.
  always_comb begin
    pconv_ext = {{2{i_pconv[17]}}, i_pconv};
    acc_d     = (row_q == 2'd0) ? pconv_ext : acc_q + pconv_ext;
  end

  always_ff @(posedge i_clk) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    if (i_rst) begin
      state_q  <= S_IDLE;
      row_q    <= 2'd0;
      acc_q    <= '0;
      data_q   <= '0;
      weight_q <= '0;
      idle_q   <= 1'b1;
      valid_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_start) begin
            data_q   <= i_win_data;
            weight_q <= i_win_weight;
            row_q    <= 2'd0;
            state_q  <= S_RUN;
            idle_q   <= 1'b0;
          end
        end
        S_RUN: begin
          acc_q <= acc_d;
          if (row_q == 2'd2) begin
            row_q   <= 2'd0;
            state_q <= S_DONE;
            valid_q <= 1'b1;
          end else begin
            row_q <= row_q + 2'd1;
          end
        end
        S_DONE: begin
          if (i_ready) begin
            state_q <= S_IDLE;
            valid_q <= 1'b0;
            idle_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          row_q   <= 2'd0;
          idle_q  <= 1'b1;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    // NOTE: defaults first so no path through this block infers a latch.
    o_pc_data   = '0;
    o_pc_weight = '0;
    if (state_q == S_RUN) begin
      case (row_q)
        2'd0: begin
          o_pc_data   = data_q[23:0];
          o_pc_weight = weight_q[23:0];
        end
        2'd1: begin
          o_pc_data   = data_q[47:24];
          o_pc_weight = weight_q[47:24];
        end
        2'd2: begin
          o_pc_data   = data_q[71:48];
          o_pc_weight = weight_q[71:48];
        end
        default: begin
          o_pc_data   = '0;
          o_pc_weight = '0;
        end
      endcase
    end
  end

`ifdef CONV_SCHED_RELU_EN
  assign o_result = acc_q[19] ? 20'd0 : acc_q;
`else
  assign o_result = acc_q;
`endif

  assign o_idle  = idle_q;
  assign o_valid = valid_q;

endmodule

// File: tb/tb_conv_sched.sv
// Bench for conv_sched: scripted datapath sums per row, vector table plus
// hand-written reset / stall / back-to-back sequences, scoreboard on handshakes.
module tb_conv_sched;

  logic        i_clk;
  logic        i_rst;
  logic        i_start;
  logic        o_idle;
  logic [71:0] i_win_data;
  logic [71:0] i_win_weight;
  logic [23:0] o_pc_data;
  logic [23:0] o_pc_weight;
  logic [17:0] i_pconv;
  logic        o_valid;
  logic        i_ready;
  logic [19:0] o_result;

  conv_sched dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_start      (i_start),
    .o_idle       (o_idle),
    .i_win_data   (i_win_data),
    .i_win_weight (i_win_weight),
    .o_pc_data    (o_pc_data),
    .o_pc_weight  (o_pc_weight),
    .i_pconv      (i_pconv),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_result     (o_result)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [71:0] data;
    logic [71:0] weight;
    int          p0;
    int          p1;
    int          p2;
    int          exp_sum;
    int          stall;
  } vec_t;

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          last_hs_cyc = 0;
  logic [19:0] exp_q[$];

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [19:0] model(input int s);
`ifdef CONV_SCHED_RELU_EN
    if (s < 0) return 20'd0;
`endif
    return 20'(s);
  endfunction

  // Scoreboard: every accepted result must match the oldest outstanding window.
  always @(negedge i_clk) begin
    if (!i_rst && o_valid && i_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 72'(o_result), 72'hDEAD);
      end else begin
        check("result", 72'(o_result), 72'(exp_q.pop_front()));
      end
      last_hs_cyc = cyc;
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (!o_idle && n < 20) begin
      @(posedge i_clk); #1;
      n++;
    end
    check("idle_before_start", 72'(o_idle), 72'd1);
  endtask

  // Entered and left at #1 after a rising edge.
  task automatic run_window(input vec_t v);
    int          ps[3];
    logic [19:0] held;
    ps = '{v.p0, v.p1, v.p2};
    wait_idle();
    i_start      = 1'b1;
    i_win_data   = v.data;
    i_win_weight = v.weight;
    exp_q.push_back(model(v.exp_sum));
    @(posedge i_clk); #1;
    i_start      = 1'b0;
    i_win_data   = 72'({$urandom, $urandom, $urandom});
    i_win_weight = 72'({$urandom, $urandom, $urandom});
    for (int r = 0; r < 3; r++) begin
      i_pconv = 18'(ps[r]);
      @(negedge i_clk);
      check($sformatf("pc_data_row%0d", r), 72'(o_pc_data), 72'(v.data[24*r +: 24]));
      check($sformatf("pc_weight_row%0d", r), 72'(o_pc_weight), 72'(v.weight[24*r +: 24]));
      check($sformatf("valid_low_row%0d", r), 72'({o_valid, o_idle}), 72'd0);
      @(posedge i_clk); #1;
    end
    i_pconv = '0;
    @(negedge i_clk);
    check("valid_latency", 72'(o_valid), 72'd1);
    check("pc_zero_done", 72'({o_pc_data, o_pc_weight}), 72'd0);
    held = o_result;
    for (int d = 0; d < v.stall; d++) begin
      @(posedge i_clk); #1;
      i_start = (d == 1);
      @(negedge i_clk);
      check("stall_valid", 72'(o_valid), 72'd1);
      check("stall_stable", 72'(o_result), 72'(held));
    end
    i_start = 1'b0;
    i_ready = 1'b1;
    @(posedge i_clk); #1;
    i_ready = 1'b0;
  endtask

  vec_t vecs[5];
  int   hs_first;

  initial begin
    vecs[0] = '{{24'h112233, 24'h445566, 24'h0A0B0C}, {24'hFEFDFC, 24'h070809, 24'h010203},
                100, -50, 7, 57, 4};
    vecs[1] = '{{24'hFFFFFF, 24'h000000, 24'h808080}, {24'h808080, 24'h7F7F7F, 24'h010101},
                -131072, -131072, -131072, -393216, 0};
    vecs[2] = '{{24'h123456, 24'h789ABC, 24'hDEF012}, {24'h0102FF, 24'h80017F, 24'h55AA55},
                131071, 131071, 131071, 393213, 1};
    vecs[3] = '{{24'hA5A5A5, 24'h5A5A5A, 24'h3C3C3C}, {24'h000000, 24'h000000, 24'h000000},
                0, 0, 0, 0, 0};
    vecs[4] = '{{24'h010203, 24'h040506, 24'h070809}, {24'hFFFFFF, 24'h020202, 24'hFEFEFE},
                -5, 3, 1, -1, 2};

    i_rst = 1'b1; i_start = 1'b0; i_ready = 1'b0; i_pconv = '0;
    i_win_data = '0; i_win_weight = '0;
    repeat (2) @(posedge i_clk);
    #1 i_rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge i_clk);
      check("rst_idle", 72'(o_idle), 72'd1);
      check("rst_valid", 72'(o_valid), 72'd0);
      check("rst_result", 72'(o_result), 72'd0);
      check("rst_pc", 72'({o_pc_data, o_pc_weight}), 72'd0);
    end
    @(posedge i_clk); #1;

    for (int i = 0; i < 5; i++) begin
      run_window(vecs[i]);
      if (vecs[i].stall > 1) begin
        check("idle_after_stall", 72'(o_idle), 72'd1);
        repeat (2) @(posedge i_clk);
        #1;
        check("no_second_window", 72'({o_idle, o_valid}), 72'b10);
      end
    end

    // Back-to-back windows with the consumer always ready.
    vecs[1].stall = 0;
    vecs[3].stall = 0;
    run_window(vecs[1]);
    hs_first = last_hs_cyc;
    run_window(vecs[3]);
    check("b2b_period", 72'(last_hs_cyc - hs_first), 72'd5);

    // Reset during the second RUN cycle, with a start asserted alongside it.
    wait_idle();
    i_start = 1'b1; i_win_data = vecs[0].data; i_win_weight = vecs[0].weight;
    @(posedge i_clk); #1;
    i_start = 1'b0; i_pconv = 18'(100);
    @(posedge i_clk); #1;
    i_pconv = 18'(-50); i_rst = 1'b1; i_start = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b0; i_start = 1'b0; i_pconv = '0;
    check("midrun_rst_idle", 72'(o_idle), 72'd1);
    check("midrun_rst_result", 72'(o_result), 72'd0);
    check("midrun_rst_pc", 72'({o_pc_data, o_pc_weight}), 72'd0);
    for (int k = 0; k < 6; k++) begin
      @(negedge i_clk);
      check("midrun_no_valid", 72'({o_idle, o_valid}), 72'b10);
    end
    @(posedge i_clk); #1;
    run_window(vecs[4]);

    repeat (2) @(posedge i_clk);
    check("scoreboard_empty", 72'(exp_q.size()), 72'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
